inst_fetch_ctrl: RTL and testbench
==================================

Name: inst_fetch_ctrl

Overview:
- Instruction-fetch sequencer for the single-cycle MIPS core.
- Owns the PC and drives the combinational instruction ROM address.
- Buffers fetched words in a 2-entry queue and presents them to decode with a valid/ready handshake.
- Handles branch/jump redirects, halt, and out-of-range or misaligned fetch errors.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset.
ROM_WORDS, 32, number of valid ROM words; word index PC[31:2] >= ROM_WORDS is out of range.
QDEPTH, 2, fetch queue depth in entries; fixed at 2 for this revision.

Ports:
Clk  in  1  rising-edge clock.
Reset  in  1  synchronous reset, active-high.
Addr  out  32  byte address to the instruction ROM; equals PC combinationally.
Inst  in  32  ROM read data for Addr, valid in the same cycle.
Redirect  in  1  branch/jump taken; load RedirectPC.
RedirectPC  in  32  redirect target, byte address.
Halt  in  1  suspend new fetches while high.
OutValid  out  1  queue head is valid.
OutReady  in  1  decode accepts the head.
OutInst  out  32  queue head instruction.
OutPC  out  32  byte address of OutInst.
FetchErr  out  1  sticky fetch fault.

Behaviour:
- Reset (synchronous): PC=RESET_PC, queue empty, OutValid=0, OutInst=0, OutPC=0, FetchErr=0, state=RUN. Reset takes priority over every other input, including mid-redirect.
- States: RUN, HALTED, ERR. State is held in a registered FSM.
- RUN, per cycle:
  - push = !Redirect & !Halt & inRange(PC) & (count<2 | pop).
  - On push, enqueue {PC, Inst} and set PC<=PC+4 (32-bit wrap; wrap is caught as out-of-range).
  - If !Redirect & !inRange(PC): no push, go to ERR, FetchErr<=1.
- pop = OutValid & OutReady; dequeues the head. Push and pop in the same cycle at count==2 is legal; count stays 2.
- Latency: an instruction at Addr in cycle N appears on OutInst in cycle N+1 at the earliest.
- Queue ordering is strict FIFO. OutInst/OutPC hold their values while OutValid & !OutReady. When empty, OutInst/OutPC hold their last values.
- Redirect (any state except reset):
  - Flush the queue (count<=0) and discard any same-cycle pop.
  - If RedirectPC[1:0]==0: PC<=RedirectPC, FetchErr<=0, state<=RUN (or HALTED if Halt).
  - If RedirectPC[1:0]!=0: state<=ERR, FetchErr<=1, PC unchanged.
  - OutValid=0 in the cycle after a redirect.
- Halt: in RUN, Halt=1 -> HALTED. HALTED issues no pushes, keeps draining pops, and holds PC. Halt=0 -> RUN, fetching resumes the same cycle.
- ERR: no pushes. Queue entries fetched before the fault still drain normally. FetchErr stays 1 until Reset or a valid Redirect.
- Addr = PC in every state.
- count is a 2-bit counter, range 0..2; never overflows or underflows.

Decomposition:
- Package cpu_fetch_pkg holds:
  - state enum {RUN, HALTED, ERR};
  - constants WORD_BYTES=4, PC_INC=32'd4, default RESET_PC.
- Sub-module fetch_queue: 2-entry synchronous FIFO of 64-bit {pc, inst} entries.
  - Ports: push, pop, flush, din, dout, count.
  - Flush has priority over push and pop.

Test Plan:
- Release Reset with OutReady=1 and ROM words 0..2 = 8C020000, 8C030001, 00432020 -> Addr steps 0,4,8. OutInst sequence 8C020000@PC0, 8C030001@PC4, 00432020@PC8, each one cycle after its fetch; FetchErr=0.
- OutReady=0 from reset -> two pushes, then PC frozen at 0x08 and OutInst stays 8C020000. Raise OutReady -> three in-order words, no duplicates or drops.
- Queue holding PC0 and PC4, then Redirect=1 with RedirectPC=0x08 -> next cycle OutValid=0. Following cycle OutInst=00432020 with OutPC=0x08; 8C030001 is never delivered.
- Redirect to 0x7C -> word at 0x7C delivered, then PC=0x80 out of range -> FetchErr=1, no further pushes. Redirect to 0x00 clears FetchErr and fetches 8C020000.
- Redirect to 0x06 -> FetchErr=1, queue empty, PC unchanged. Assert Reset mid-ERR -> PC=0, FetchErr=0, OutValid=0.
- Halt=1 while 2 entries are queued -> queue drains to empty and Addr holds. Drop Halt -> fetch resumes at the held PC with no skipped address.

Source files
------------

// File: rtl/cpu_fetch_pkg.sv
// cpu_fetch_pkg: shared types and constants for the instruction-fetch sequencer
package cpu_fetch_pkg;

    typedef enum logic [1:0] {RUN, HALTED, ERR} state_e;

    localparam int          WORD_BYTES       = 4;
    localparam logic [31:0] PC_INC           = 32'(WORD_BYTES);
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: 2-entry shift FIFO of {pc, inst}; head stays put when it drains empty
module fetch_queue (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        push_i,
    input  logic        pop_i,
    input  logic        flush_i,
    input  logic [63:0] din_i,
    output logic [63:0] dout_o,
    output logic [1:0]  count_o
);

    logic [1:0]  count_q;
    logic [63:0] e0_q, e1_q;
    logic        do_pop, do_push;

    assign do_pop  = pop_i && count_q != 2'd0;
    assign do_push = push_i && (count_q != 2'd2 || do_pop);
    assign dout_o  = e0_q;
    assign count_o = count_q;

    // Entry 0 is always the head; popping a lone entry leaves its data visible
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= 2'd0;
            e0_q    <= 64'd0;
            e1_q    <= 64'd0;
        end else if (flush_i) begin
            count_q <= 2'd0;
        end else begin
            if (do_pop && count_q == 2'd2) e0_q <= e1_q;
            if (do_push) begin
                if (count_q == 2'd0 || (do_pop && count_q == 2'd1)) e0_q <= din_i;
                else e1_q <= din_i;
            end
            count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

endmodule

// File: rtl/inst_fetch_ctrl.sv
// inst_fetch_ctrl: PC sequencer feeding decode through a 2-entry fetch queue
module inst_fetch_ctrl
    import cpu_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int          ROM_WORDS = 32,
    parameter int          QDEPTH    = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    output logic [31:0] Addr,
    input  logic [31:0] Inst,
    input  logic        Redirect,
    input  logic [31:0] RedirectPC,
    input  logic        Halt,
    output logic        OutValid,
    input  logic        OutReady,
    output logic [31:0] OutInst,
    output logic [31:0] OutPC,
    output logic        FetchErr
);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        err_q, err_d;
    logic [1:0]  count;
    logic [63:0] head;
    logic        in_range, fetch_ok, push, pop;

    assign Addr     = pc_q;
    assign FetchErr = err_q;
    assign OutValid = count != 2'd0;
    assign OutPC    = head[63:32];
    assign OutInst  = head[31:0];
    assign in_range = {2'b00, pc_q[31:2]} < 32'(ROM_WORDS);
    assign pop      = OutValid && OutReady;
    assign fetch_ok = !Redirect && state_q != ERR && !Halt && in_range;
    assign push     = fetch_ok && (count < 2'(QDEPTH) || pop);

    fetch_queue u_queue (
        .clk_i   (Clk),
        .rst_i   (Reset),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (Redirect),
        .din_i   ({pc_q, Inst}),
        .dout_o  (head),
        .count_o (count)
    );

    // Next PC / state: redirect wins, then halt, then range fault, else sequential fetch
    always_comb begin
        pc_d    = pc_q;
        state_d = state_q;
        err_d   = err_q;
        if (Redirect) begin
            if (RedirectPC[1:0] == 2'b00) begin
                pc_d    = RedirectPC;
                err_d   = 1'b0;
                state_d = Halt ? HALTED : RUN;
            end else begin
                state_d = ERR;
                err_d   = 1'b1;
            end
        end else if (state_q != ERR) begin
            if (Halt) begin
                state_d = HALTED;
            end else if (!in_range) begin
                state_d = ERR;
                err_d   = 1'b1;
            end else begin
                state_d = RUN;
                pc_d    = push ? pc_q + PC_INC : pc_q;
            end
        end
    end

    // Fetch FSM registers with synchronous reset
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// tb_inst_fetch_ctrl: directed scenario bench for the fetch sequencer
module tb_inst_fetch_ctrl;

    logic        Clk = 1'b0;
    logic        Reset, Redirect, Halt, OutReady;
    logic [31:0] RedirectPC;
    logic [31:0] Addr, Inst, OutInst, OutPC;
    logic        OutValid, FetchErr;
    logic [31:0] rom [32];
    logic [31:0] exp_inst [3];
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 Clk = ~Clk;

    assign Inst = (Addr[31:7] == 25'd0) ? rom[Addr[6:2]] : 32'h0;

    inst_fetch_ctrl dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Addr       (Addr),
        .Inst       (Inst),
        .Redirect   (Redirect),
        .RedirectPC (RedirectPC),
        .Halt       (Halt),
        .OutValid   (OutValid),
        .OutReady   (OutReady),
        .OutInst    (OutInst),
        .OutPC      (OutPC),
        .FetchErr   (FetchErr)
    );

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b1; Redirect = 1'b0; Halt = 1'b0; OutReady = 1'b0; RedirectPC = 32'h0;
        step();
        step();
        Reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (Addr !== 32'h0) begin n_bad++; $display("FAIL reset_addr got %h want %h", Addr, 32'h0); end
        n_cmp++; if (OutValid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", OutValid); end
        n_cmp++; if (OutInst !== 32'h0) begin n_bad++; $display("FAIL reset_inst got %h want 0", OutInst); end
        n_cmp++; if (OutPC !== 32'h0) begin n_bad++; $display("FAIL reset_pc got %h want 0", OutPC); end
        n_cmp++; if (FetchErr !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b want 0", FetchErr); end
    endtask

    task automatic test_stream();
        do_reset();
        OutReady = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (Addr !== 32'(4 * i)) begin n_bad++; $display("FAIL stream_addr%0d got %h want %h", i, Addr, 32'(4 * i)); end
            step();
            n_cmp++; if (OutValid !== 1'b1 || OutInst !== exp_inst[i] || OutPC !== 32'(4 * i))
                begin n_bad++; $display("FAIL stream_out%0d got v=%b %h@%h want 1 %h@%h", i, OutValid, OutInst, OutPC, exp_inst[i], 32'(4 * i)); end
        end
        n_cmp++; if (FetchErr !== 1'b0) begin n_bad++; $display("FAIL stream_err got %b want 0", FetchErr); end
    endtask

    task automatic test_backpressure();
        do_reset();
        step();
        step();
        step();
        n_cmp++; if (Addr !== 32'h8) begin n_bad++; $display("FAIL bp_addr_frozen got %h want 8", Addr); end
        n_cmp++; if (OutValid !== 1'b1 || OutInst !== 32'h8C020000 || OutPC !== 32'h0)
            begin n_bad++; $display("FAIL bp_head_hold got v=%b %h@%h want 1 8c020000@0", OutValid, OutInst, OutPC); end
        OutReady = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (OutValid !== 1'b1 || OutInst !== exp_inst[i] || OutPC !== 32'(4 * i))
                begin n_bad++; $display("FAIL bp_drain%0d got v=%b %h@%h want 1 %h@%h", i, OutValid, OutInst, OutPC, exp_inst[i], 32'(4 * i)); end
            step();
        end
    endtask

    task automatic test_redirect();
        do_reset();
        step();
        step();
        Redirect = 1'b1; RedirectPC = 32'h8; OutReady = 1'b1;
        step();
        Redirect = 1'b0;
        n_cmp++; if (OutValid !== 1'b0) begin n_bad++; $display("FAIL redir_flush got %b want 0", OutValid); end
        n_cmp++; if (Addr !== 32'h8) begin n_bad++; $display("FAIL redir_addr got %h want 8", Addr); end
        step();
        n_cmp++; if (OutValid !== 1'b1 || OutInst !== 32'h00432020 || OutPC !== 32'h8)
            begin n_bad++; $display("FAIL redir_first got v=%b %h@%h want 1 00432020@8", OutValid, OutInst, OutPC); end
        step();
        n_cmp++; if (OutPC !== 32'hC || OutInst !== rom[3]) begin n_bad++; $display("FAIL redir_second got %h@%h want %h@c", OutInst, OutPC, rom[3]); end
    endtask

    task automatic test_range_err();
        do_reset();
        Redirect = 1'b1; RedirectPC = 32'h7C;
        step();
        Redirect = 1'b0; OutReady = 1'b1;
        step();
        n_cmp++; if (OutValid !== 1'b1 || OutInst !== 32'hDEADBEEF || OutPC !== 32'h7C)
            begin n_bad++; $display("FAIL range_last got v=%b %h@%h want 1 deadbeef@7c", OutValid, OutInst, OutPC); end
        n_cmp++; if (FetchErr !== 1'b0) begin n_bad++; $display("FAIL range_err_early got %b want 0", FetchErr); end
        step();
        n_cmp++; if (FetchErr !== 1'b1 || OutValid !== 1'b0 || Addr !== 32'h80)
            begin n_bad++; $display("FAIL range_fault got err=%b v=%b addr=%h want 1 0 80", FetchErr, OutValid, Addr); end
        step();
        n_cmp++; if (FetchErr !== 1'b1 || OutValid !== 1'b0 || Addr !== 32'h80)
            begin n_bad++; $display("FAIL range_sticky got err=%b v=%b addr=%h want 1 0 80", FetchErr, OutValid, Addr); end
        Redirect = 1'b1; RedirectPC = 32'h0;
        step();
        Redirect = 1'b0;
        n_cmp++; if (FetchErr !== 1'b0 || Addr !== 32'h0) begin n_bad++; $display("FAIL range_clear got err=%b addr=%h want 0 0", FetchErr, Addr); end
        step();
        n_cmp++; if (OutValid !== 1'b1 || OutInst !== 32'h8C020000 || OutPC !== 32'h0)
            begin n_bad++; $display("FAIL range_resume got v=%b %h@%h want 1 8c020000@0", OutValid, OutInst, OutPC); end
    endtask

    task automatic test_misaligned();
        do_reset();
        step();
        Redirect = 1'b1; RedirectPC = 32'h6;
        step();
        Redirect = 1'b0;
        n_cmp++; if (FetchErr !== 1'b1 || OutValid !== 1'b0 || Addr !== 32'h4)
            begin n_bad++; $display("FAIL misal_fault got err=%b v=%b addr=%h want 1 0 4", FetchErr, OutValid, Addr); end
        step();
        n_cmp++; if (OutValid !== 1'b0 || Addr !== 32'h4) begin n_bad++; $display("FAIL misal_nopush got v=%b addr=%h want 0 4", OutValid, Addr); end
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        n_cmp++; if (FetchErr !== 1'b0 || OutValid !== 1'b0 || Addr !== 32'h0 || OutInst !== 32'h0)
            begin n_bad++; $display("FAIL misal_reset got err=%b v=%b addr=%h inst=%h want 0 0 0 0", FetchErr, OutValid, Addr, OutInst); end
    endtask

    task automatic test_halt();
        do_reset();
        step();
        step();
        Halt = 1'b1; OutReady = 1'b1;
        step();
        n_cmp++; if (OutValid !== 1'b1 || OutPC !== 32'h4 || Addr !== 32'h8)
            begin n_bad++; $display("FAIL halt_drain1 got v=%b pc=%h addr=%h want 1 4 8", OutValid, OutPC, Addr); end
        step();
        n_cmp++; if (OutValid !== 1'b0 || Addr !== 32'h8) begin n_bad++; $display("FAIL halt_empty got v=%b addr=%h want 0 8", OutValid, Addr); end
        n_cmp++; if (OutPC !== 32'h4 || OutInst !== 32'h8C030001)
            begin n_bad++; $display("FAIL halt_hold_last got %h@%h want 8c030001@4", OutInst, OutPC); end
        step();
        n_cmp++; if (Addr !== 32'h8) begin n_bad++; $display("FAIL halt_addr_hold got %h want 8", Addr); end
        Halt = 1'b0;
        step();
        n_cmp++; if (OutValid !== 1'b1 || OutInst !== 32'h00432020 || OutPC !== 32'h8 || Addr !== 32'hC)
            begin n_bad++; $display("FAIL halt_resume got v=%b %h@%h addr=%h want 1 00432020@8 c", OutValid, OutInst, OutPC, Addr); end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rom[i] = 32'h2000_0000 | 32'(i);
        rom[0] = 32'h8C020000;
        rom[1] = 32'h8C030001;
        rom[2] = 32'h00432020;
        rom[31] = 32'hDEADBEEF;
        exp_inst[0] = 32'h8C020000;
        exp_inst[1] = 32'h8C030001;
        exp_inst[2] = 32'h00432020;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_range_err();
        test_misaligned();
        test_halt();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
